chunked_add_sequencer: RTL and testbench

//   Multi-cycle wide adder. Adds two CHUNK*NCHUNK-bit operands by reusing one

---
 rtl/chunked_add_sequencer.sv | 174 +++++++++++++++++
 tb/tb_chunked_add_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/chunked_add_sequencer.sv
// Multi-cycle wide adder: one CHUNK-bit ripple-carry adder reused over NCHUNK passes, LSB chunk first.
// Optional feature macro ADD_SUB_EN adds a `sub` input for two's-complement subtraction.

module n_bit_rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out_final
);
    logic [N:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out_final = carry[N];
endmodule

// state | meaning
// IDLE  | waiting for start; sum/c_out hold the last result
// RUN   | feeding one chunk per WAIT_CYC clocks through the shared adder
// DONE  | one-cycle done pulse, then back to IDLE
module chunked_add_sequencer #(
    parameter int CHUNK    = 4,
    parameter int NCHUNK   = 4,
    parameter int WAIT_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CHUNK*NCHUNK-1:0]    a,
    input  logic [CHUNK*NCHUNK-1:0]    b,
    input  logic                       c_in,
`ifdef ADD_SUB_EN
    input  logic                       sub,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [CHUNK*NCHUNK-1:0]    sum,
    output logic                       c_out
);
    localparam int TOTAL = CHUNK * NCHUNK;
    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TOTAL-1:0]   a_q, a_d;
    logic [TOTAL-1:0]   b_q, b_d;
    logic               cy_q, cy_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TOTAL-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;

    logic [TOTAL-1:0]   b_eff;
    logic               cy_eff;
    logic [31:0]        chunk_base;
    logic [CHUNK-1:0]   rca_a;
    logic [CHUNK-1:0]   rca_b;
    logic [CHUNK-1:0]   rca_s;
    logic               rca_co;

`ifdef ADD_SUB_EN
    // Subtraction as a + ~b + 1; the incoming carry is replaced, not added.
    assign b_eff  = sub ? ~b : b;
    assign cy_eff = sub ? 1'b1 : c_in;
`else
    assign b_eff  = b;
    assign cy_eff = c_in;
`endif

    assign chunk_base = 32'(idx_q) * 32'(CHUNK);
    assign rca_a      = a_q[chunk_base +: CHUNK];
    assign rca_b      = b_q[chunk_base +: CHUNK];

    n_bit_rca #(
        .N (CHUNK)
    ) u_rca (
        .a           (rca_a),
        .b           (rca_b),
        .c_in        (cy_q),
        .s           (rca_s),
        .c_out_final (rca_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cy_q    <= cy_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cy_d    = cy_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_eff;
                    cy_d    = cy_eff;
                    idx_d   = '0;
                    cnt_d   = '0;
                    sum_d   = '0;
                    c_out_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The chunk is held for WAIT_CYC clocks so the ripple settles before capture.
                if (cnt_q == CNT_LAST) begin
                    sum_d[chunk_base +: CHUNK] = rca_s;
                    cy_d  = rca_co;
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        c_out_d = rca_co;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Scoreboard bench for chunked_add_sequencer (CHUNK=4, NCHUNK=4, WAIT_CYC=3).
// Define ADD_SUB_EN to include the subtraction vectors.

module tb_chunked_add_sequencer;
    localparam int LAT = 13;

    typedef struct {
        logic [16:0] exp;
        int          start_cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        c_in = 1'b0;
    logic        sub = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic done_prev = 1'b0;
    logic [16:0] last_exp = '0;
    exp_t q[$];

    chunked_add_sequencer #(
        .CHUNK    (4),
        .NCHUNK   (4),
        .WAIT_CYC (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
`ifdef ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                e = q.pop_front();
                check({e.name, "_result"}, 32'({c_out, sum}), 32'(e.exp));
                // Cycle count to the edge that closes the done cycle.
                check({e.name, "_latency"}, 32'(cyc + 1 - e.start_cyc), 32'(LAT));
            end
            if (done_prev) check("done_width", 32'(done_prev), 32'(0));
        end
        done_prev <= done;
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({name, "_idle_timeout"}, 32'(busy), 32'(0));
    endtask

    task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input logic ts, input logic [16:0] exp_v, input logic push);
        exp_t e;
        wait_idle(name);
        a     = ta;
        b     = tb_v;
        c_in  = tc;
        sub   = ts;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.exp       = exp_v;
            e.start_cyc = cyc;
            e.name      = name;
            q.push_back(e);
            last_exp    = exp_v;
        end
        check({name, "_busy"}, 32'(busy), 32'(1));
    endtask

    initial begin
        int n;

        // Reset with start asserted: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        check("rst_busy",  32'(busy),  32'(0));
        check("rst_done",  32'(done),  32'(0));
        check("rst_sum",   32'(sum),   32'h0000);
        check("rst_c_out", 32'(c_out), 32'(0));
        rst = 1'b0;

        run_op("t2_small_carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h0_0100, 1'b1);
        run_op("t3_full_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000, 1'b1);

        // Start pulsed during RUN with different operands must be ignored.
        run_op("t4_cin",         16'h1234, 16'h4321, 1'b1, 1'b0, 17'h0_5556, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        c_in  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        // Reset during RUN: no done, outputs cleared.
        run_op("t5_abort",       16'h8000, 16'h8000, 1'b0, 1'b0, 17'h1_0000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy",  32'(busy),  32'(0));
        check("abort_done",  32'(done),  32'(0));
        check("abort_sum",   32'(sum),   32'h0000);
        check("abort_c_out", 32'(c_out), 32'(0));

        run_op("t5_msb_carry",   16'h8000, 16'h8000, 1'b0, 1'b0, 17'h1_0000, 1'b1);
        run_op("b2b_mix",        16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 17'h1_0000, 1'b1);
        run_op("chunk_mid",      16'h0F0F, 16'h00F1, 1'b1, 1'b0, 17'h0_1001, 1'b1);
`ifdef ADD_SUB_EN
        run_op("t6_sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0_FFFE, 1'b1);
        run_op("t6_sub_ok",      16'h0007, 16'h0005, 1'b0, 1'b1, 17'h1_0002, 1'b1);
        run_op("t6_sub_zero_add",16'h0007, 16'h0005, 1'b1, 1'b0, 17'h0_000D, 1'b1);
`endif

        n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(q.size()), 32'(0));

        // Result must hold while idle.
        repeat (5) @(posedge clk);
        #1;
        check("hold_result", 32'({c_out, sum}), 32'(last_exp));
        check("hold_idle",   32'(busy),         32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
